// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes symbolic MIPS instructions and loads them into IMEM
module instr_encoder_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_busy,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t      state;
  logic        last_q;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        is_r;
  logic        is_j;
  logic        is_shift;
  logic        enc_legal;
  logic [31:0] enc_word;

  always_comb begin
    op        = 6'b000000;
    func      = 6'b000000;
    is_r      = 1'b0;
    is_j      = 1'b0;
    is_shift  = 1'b0;
    enc_legal = 1'b1;
    case (in_mnem)
      5'd0:  begin is_r = 1'b1; func = 6'b100000; end
      5'd1:  begin is_r = 1'b1; func = 6'b100001; end
      5'd2:  begin is_r = 1'b1; func = 6'b100100; end
      5'd3:  begin is_r = 1'b1; func = 6'b100111; end
      5'd4:  begin is_r = 1'b1; func = 6'b100101; end
      5'd5:  begin is_r = 1'b1; is_shift = 1'b1; func = 6'b000000; end
      5'd6:  begin is_r = 1'b1; is_shift = 1'b1; func = 6'b000011; end
      5'd7:  begin is_r = 1'b1; is_shift = 1'b1; func = 6'b000010; end
      5'd8:  begin is_r = 1'b1; func = 6'b100010; end
      5'd9:  begin is_r = 1'b1; func = 6'b001000; end
      5'd10: begin is_r = 1'b1; func = 6'b001100; end
      5'd11: begin is_r = 1'b1; func = 6'b101010; end
      5'd12: begin is_r = 1'b1; func = 6'b101011; end
      5'd13: op = 6'b001000;
      5'd14: op = 6'b001001;
      5'd15: op = 6'b001100;
      5'd16: op = 6'b001101;
      5'd17: op = 6'b000100;
      5'd18: op = 6'b000101;
      5'd19: begin is_j = 1'b1; op = 6'b000010; end
      5'd20: begin is_j = 1'b1; op = 6'b000011; end
      5'd21: op = 6'b100011;
      5'd22: op = 6'b101011;
      5'd23: op = 6'b001010;
      default: enc_legal = 1'b0;
    endcase

    // jr and syscall ignore most fields so stray operands never leak into the word
    if (is_r) begin
      if (in_mnem == 5'd9)
        enc_word = {6'b000000, in_rs, 15'd0, func};
      else if (in_mnem == 5'd10)
        enc_word = 32'h0000000C;
      else
        enc_word = {6'b000000, is_shift ? 5'd0 : in_rs, in_rt, in_rd,
                    is_shift ? in_shamt : 5'd0, func};
    end else if (is_j) begin
      enc_word = {op, in_imm};
    end else begin
      enc_word = {op, in_rs, in_rt, in_imm[15:0]};
    end
  end

  assign in_ready = (state == ACCEPT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_q    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (start) begin
      state  <= ACCEPT;
      mem_we <= 1'b0;
      count  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        ACCEPT: if (in_valid) begin
          if (!enc_legal) begin
            err <= 1'b1;
            if (in_last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (count[ADDR_W]) begin
            // memory already full: drop the item and end the load
            err   <= 1'b1;
            state <= DONE;
            done  <= 1'b1;
          end else begin
            mem_wdata <= enc_word;
            mem_addr  <= count[ADDR_W-1:0];
            mem_we    <= 1'b1;
            last_q    <= in_last;
            state     <= WRITE;
          end
        end
        WRITE: if (!mem_busy) begin
          mem_we <= 1'b0;
          count  <= count + (ADDR_W+1)'(1);
          if (last_q) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= ACCEPT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed bench for instr_encoder_loader
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        mem_busy = 1'b0;
  logic [4:0]  in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [25:0] in_imm = '0;

  logic        in_ready, mem_we, done, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] count;

  logic        ready2, mem_we2, done2, err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  count2;

  int errors = 0;
  int checks = 0;
  logic [9:0] log_addr[$];
  logic [1:0] log2_addr[$];

  instr_encoder_loader #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_busy(mem_busy), .count(count), .done(done), .err(err)
  );

  instr_encoder_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ready2),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_busy(mem_busy), .count(count2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  // commit log: a write lands when strobed, not stalled and not pre-empted by start
  always @(posedge clk) begin
    if (rst_n && !start && mem_we && !mem_busy) log_addr.push_back(mem_addr);
    if (rst_n && !start && mem_we2 && !mem_busy) log2_addr.push_back(mem_addr2);
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm,
                      input logic last, input logic sel);
    bit got;
    @(negedge clk);
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
    in_last = last; in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sel ? ready2 : in_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout: ready=%0b required=1", sel ? ready2 : in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, count, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%0b we=%0b addr=%0d wdata=%h count=%0d done=%0b err=%0b required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, count, done, err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_not_ready: in_ready=%0b required 0", in_ready); end
  endtask

  task automatic test_basic();
    pulse_start();
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 32'h00221820 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_write: we=%0b addr=%0d wdata=%h ready=%0b required 1 0 00221820 0", mem_we, mem_addr, mem_wdata, in_ready);
    end
    @(negedge clk);
    checks++;
    if (count !== 11'd1 || mem_we !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_commit: count=%0d we=%0b ready=%0b required 1 0 1", count, mem_we, in_ready);
    end
    send(5'd13, 5'd0, 5'd8, 5'd0, 5'd0, 26'h000FFFF, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (mem_addr !== 10'd1 || mem_wdata !== 32'h2008FFFF) begin
      errors++;
      $display("FAIL addi_word: addr=%0d wdata=%h required 1 2008ffff", mem_addr, mem_wdata);
    end
    send(5'd5, 5'd7, 5'd1, 5'd2, 5'd4, 26'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (mem_addr !== 10'd2 || mem_wdata !== 32'h00011100) begin
      errors++;
      $display("FAIL sll_word: addr=%0d wdata=%h required 2 00011100", mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (count !== 11'd3 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_count: count=%0d done=%0b required 3 0", count, done);
    end
  endtask

  task automatic test_last();
    int n0;
    pulse_start();
    n0 = log_addr.size();
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b0, 1'b0);
    send(5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0000010, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (mem_addr !== 10'd1 || mem_wdata !== 32'h0C000010) begin
      errors++;
      $display("FAIL jal_word: addr=%0d wdata=%h required 1 0c000010", mem_addr, mem_wdata);
    end
    send(5'd10, 5'd5, 5'd6, 5'd7, 5'd3, 26'h3FFFFFF, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (mem_addr !== 10'd2 || mem_wdata !== 32'h0000000C || done !== 1'b0) begin
      errors++;
      $display("FAIL syscall_word: addr=%0d wdata=%h done=%0b required 2 0000000c 0", mem_addr, mem_wdata, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || count !== 11'd3 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL last_done: done=%0b count=%0d ready=%0b required 1 3 0", done, count, in_ready);
    end
    checks++;
    if (log_addr.size() !== n0 + 3 || log_addr[n0] !== 10'd0 || log_addr[n0+1] !== 10'd1 || log_addr[n0+2] !== 10'd2) begin
      errors++;
      $display("FAIL last_addrs: writes=%0d required 3 at addrs 0,1,2", log_addr.size() - n0);
    end
  endtask

  task automatic test_stall();
    pulse_start();
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b0, 1'b0);
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 32'h00221820 || in_ready !== 1'b0 || count !== 11'd0) begin
        errors++;
        $display("FAIL stall_hold: cyc=%0d we=%0b addr=%0d wdata=%h ready=%0b count=%0d required 1 0 00221820 0 0",
                 i, mem_we, mem_addr, mem_wdata, in_ready, count);
      end
    end
    mem_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 11'd1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL stall_commit: count=%0d we=%0b required 1 0", count, mem_we);
    end
    send(5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || mem_we !== 1'b0 || count !== 11'd1 || in_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL illegal_item: err=%0b we=%0b count=%0d ready=%0b done=%0b required 1 0 1 1 0", err, mem_we, count, in_ready, done);
    end
    send(5'd16, 5'd1, 5'd2, 5'd0, 5'd0, 26'h00000FF, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 10'd1 || mem_wdata !== 32'h342200FF || err !== 1'b1) begin
      errors++;
      $display("FAIL after_illegal: we=%0b addr=%0d wdata=%h err=%0b required 1 1 342200ff 1", mem_we, mem_addr, mem_wdata, err);
    end
    @(negedge clk);
    checks++;
    if (count !== 11'd2) begin errors++; $display("FAIL after_illegal_count: count=%0d required 2", count); end
  endtask

  task automatic test_overflow();
    pulse_start();
    log2_addr.delete();
    for (int i = 0; i < 4; i++)
      send(5'd16, 5'd0, 5'(i), 5'd0, 5'd0, 26'(i), 1'b0, 1'b1);
    send(5'd16, 5'd0, 5'd9, 5'd0, 5'd0, 26'd9, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (err2 !== 1'b1 || done2 !== 1'b1 || count2 !== 3'd4 || mem_we2 !== 1'b0 || ready2 !== 1'b0) begin
      errors++;
      $display("FAIL overflow: err=%0b done=%0b count=%0d we=%0b ready=%0b required 1 1 4 0 0", err2, done2, count2, mem_we2, ready2);
    end
    checks++;
    if (log2_addr.size() !== 4 || log2_addr[0] !== 2'd0 || log2_addr[1] !== 2'd1 || log2_addr[2] !== 2'd2 || log2_addr[3] !== 2'd3) begin
      errors++;
      $display("FAIL overflow_addrs: writes=%0d required 4 at addrs 0..3", log2_addr.size());
    end
  endtask

  task automatic test_async_reset();
    int n0;
    pulse_start();
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b0, 1'b0);
    @(negedge clk);
    n0 = log_addr.size();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, count, done, err} !== '0) begin
      errors++;
      $display("FAIL async_reset: ready=%0b we=%0b addr=%0d wdata=%h count=%0d done=%0b err=%0b required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, count, done, err);
    end
    @(posedge clk); #1;
    checks++;
    if (log_addr.size() !== n0) begin errors++; $display("FAIL reset_no_write: writes=%0d required 0", log_addr.size() - n0); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_restart();
    int n0;
    pulse_start();
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b0, 1'b0);
    send(5'd13, 5'd0, 5'd8, 5'd0, 5'd0, 26'h000FFFF, 1'b0, 1'b0);
    @(negedge clk);
    n0 = log_addr.size();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (count !== 11'd0 || mem_we !== 1'b0 || in_ready !== 1'b1 || log_addr.size() !== n0) begin
      errors++;
      $display("FAIL restart: count=%0d we=%0b ready=%0b writes=%0d required 0 0 1 0", count, mem_we, in_ready, log_addr.size() - n0);
    end
    send(5'd16, 5'd1, 5'd2, 5'd0, 5'd0, 26'h00000FF, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (mem_addr !== 10'd0 || mem_wdata !== 32'h342200FF) begin
      errors++;
      $display("FAIL restart_addr: addr=%0d wdata=%h required 0 342200ff", mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (count !== 11'd1) begin errors++; $display("FAIL restart_count: count=%0d required 1", count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_last();
    test_stall();
    test_overflow();
    test_async_reset();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
